// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and a two's-complement helper.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Wide enough for the 2W product at any supported DATA_WIDTH (up to 64);
  // callers zero-extend in and truncate out.
  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  flush;
  logic                  mf_access;
  logic                  busy;
  logic                  done;
  logic                  stall;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, mf_access,
                  input  busy, done, stall, hi, lo);
  modport slave  (input  start, op, a, b, flush, mf_access,
                  output busy, done, stall, hi, lo);
endinterface

// File: rtl/mdu_shift_core.sv
// 2W-bit shift register shared by shift-add multiply and restoring divide.
// Multiply: {partial_product, multiplier}, shifts right.
// Divide:   {partial_remainder, dividend/quotient}, shifts left.
module mdu_shift_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic                    div_i,
  input  logic                    step_i,
  input  logic [DATA_WIDTH-1:0]   load_val_i,
  input  logic [DATA_WIDTH-1:0]   m_i,
  output logic [2*DATA_WIDTH-1:0] acc_o
);
  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   m_q;
  logic           div_q;
  logic [W:0]     sum;
  logic [W:0]     shrem;
  logic           ge;
  logic [W-1:0]   newrem;

  // One iteration of either algorithm, or a fresh load.
  always_comb begin
    sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    shrem  = acc_q[2*W-1:W-1];
    ge     = (shrem >= {1'b0, m_q});
    newrem = ge ? W'(shrem - {1'b0, m_q}) : shrem[W-1:0];
    acc_d  = acc_q;
    if (load_i) begin
      acc_d = {{W{1'b0}}, load_val_i};
    end else if (step_i) begin
      acc_d = div_q ? {newrem, acc_q[W-2:0], ge} : {sum, acc_q[W-1:1]};
    end
  end

  // Accumulator, operand and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        m_q   <= m_i;
        div_q <= div_i;
      end
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   state | meaning
//   IDLE  | waiting; MTHI/MTLO write HI/LO directly
//   RUN   | W iterations of shift-add or restoring divide on magnitudes
//   FIX   | apply sign correction, write HI/LO, pulse done
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave mdu
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic           sa_q, sa_d, sb_q, sb_d;
  logic           done_q, done_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] acc;

  logic           in_signed, in_div, accept, launch, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W-1:0]   res_hi, res_lo;

  assign in_signed = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);
  assign in_div    = (mdu.op == OP_DIV)  || (mdu.op == OP_DIVU);
  assign accept    = (state_q == IDLE) && mdu.start && !mdu.flush;
  assign launch    = accept && !mdu.op[2];
  assign a_neg     = in_signed && mdu.a[W-1];
  assign b_neg     = in_signed && mdu.b[W-1];
  assign a_mag     = a_neg ? W'(neg(NEG_W'(mdu.a))) : mdu.a;
  assign b_mag     = b_neg ? W'(neg(NEG_W'(mdu.b))) : mdu.b;

  mdu_shift_core #(.DATA_WIDTH(W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (launch),
    .div_i      (in_div),
    .step_i     ((state_q == RUN) && !mdu.flush),
    .load_val_i (in_div ? a_mag : b_mag),
    .m_i        (in_div ? b_mag : a_mag),
    .acc_o      (acc)
  );

  // Sign correction of the magnitude result; sa/sb are zero for unsigned ops.
  always_comb begin
    if (op_q[1]) begin
      res_hi = sa_q ? W'(neg(NEG_W'(acc[2*W-1:W]))) : acc[2*W-1:W];
      res_lo = (sa_q ^ sb_q) ? W'(neg(NEG_W'(acc[W-1:0]))) : acc[W-1:0];
    end else begin
      {res_hi, res_lo} = (sa_q ^ sb_q) ? (2*W)'(neg(NEG_W'(acc))) : acc;
    end
  end

  // Next state, iteration counter and operation latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (launch) begin
        state_d = RUN;
        cnt_d   = '0;
        op_d    = mdu.op[1:0];
        sa_d    = a_neg;
        sb_d    = b_neg;
      end
      RUN: begin
        if (mdu.flush)                  state_d = IDLE;
        else if (cnt_q == CW'(W - 1))   state_d = FIX;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      FIX: begin
        state_d = IDLE;
        done_d  = !mdu.flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // HI/LO writes from MTHI/MTLO or a completed operation.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && mdu.op == OP_MTHI) hi_d = mdu.a;
    if (accept && mdu.op == OP_MTLO) lo_d = mdu.a;
    if (state_q == FIX && !mdu.flush) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.busy  = (state_q != IDLE);
  assign mdu.done  = done_q;
  assign mdu.stall = mdu.busy && (mdu.mf_access || mdu.start);
  assign mdu.hi    = hi_q;
  assign mdu.lo    = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random back-to-back
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.DATA_WIDTH(W)) mdu ();
  mult_div_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .mdu(mdu));

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [63:0] p;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; {hi, lo} = p; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
      OP_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          p = sa / sb; lo = p[31:0];
          p = sa % sb; hi = p[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input int flush_at, input int extra_at, input int reset_at,
                        output int done_cyc, output int busy_cnt, output int done_cnt);
    mdu.op = op_v; mdu.a = a_v; mdu.b = b_v; mdu.start = 1'b1;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (reset_at != 0 && cyc == reset_at + 1) begin
        check("reset_mid_busy", 64'(mdu.busy), 64'(0));
        check("reset_mid_hi", 64'(mdu.hi), 64'(0));
        check("reset_mid_lo", 64'(mdu.lo), 64'(0));
      end
      if (flush_at != 0 && cyc == flush_at + 1)
        check("flush_busy_low", 64'(mdu.busy), 64'(0));
      if (mdu.busy) busy_cnt++;
      if (mdu.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      mdu.flush = (cyc == flush_at);
      reset     = (cyc == reset_at);
      if (cyc == extra_at) begin
        mdu.start = 1'b1; mdu.mf_access = 1'b1;
        mdu.op = OP_DIVU; mdu.a = 32'd100; mdu.b = 32'd3;
        #1;
        check("stall_when_busy", 64'(mdu.stall), 64'(1));
      end else begin
        mdu.start = 1'b0; mdu.mf_access = 1'b0;
      end
      if (mdu.done && flush_at == 0 && extra_at == 0 && reset_at == 0) break;
      @(posedge clk); #1;
    end
    mdu.start = 1'b0; mdu.mf_access = 1'b0; mdu.flush = 1'b0; reset = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] op_v,
                               input logic [31:0] a_v, input logic [31:0] b_v);
    int dc, bc, nc;
    logic [31:0] eh, el;
    model(op_v, a_v, b_v, eh, el);
    run_op(op_v, a_v, b_v, 0, 0, 0, dc, bc, nc);
    check({tag, "_done_cycle"}, 64'(dc), 64'(W + 2));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    check({tag, "_hi"}, 64'(mdu.hi), 64'(eh));
    check({tag, "_lo"}, 64'(mdu.lo), 64'(el));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, bc, nc;
    logic [31:0] eh, el;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    mdu.start = 1'b0; mdu.op = '0; mdu.a = '0; mdu.b = '0;
    mdu.flush = 1'b0; mdu.mf_access = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_hi", 64'(mdu.hi), 64'(0));
    check("rst_lo", 64'(mdu.lo), 64'(0));
    check("rst_busy", 64'(mdu.busy), 64'(0));
    check("rst_done", 64'(mdu.done), 64'(0));
    check("rst_stall", 64'(mdu.stall), 64'(0));

    mdu.mf_access = 1'b1; #1;
    check("stall_idle_mf", 64'(mdu.stall), 64'(0));
    mdu.mf_access = 1'b0;
    @(posedge clk); #1;

    run_and_check("mult_neg1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_neg1x2_hi_const", 64'(mdu.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg1x2_lo_const", 64'(mdu.lo), 64'h0000_0000_FFFF_FFFE);
    run_and_check("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_const", 64'(mdu.hi), 64'h1);
    run_and_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lo_const", 64'(mdu.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2_hi_const", 64'(mdu.hi), 64'h0000_0000_FFFF_FFFF);
    run_and_check("divu_7_0", OP_DIVU, 32'd7, 32'd0);
    check("divu_7_0_lo_const", 64'(mdu.lo), 64'h0000_0000_FFFF_FFFF);
    run_and_check("div_sdiv0", OP_DIV, 32'hFFFF_FFF9, 32'd0);
    run_and_check("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg_lo_const", 64'(mdu.lo), 64'h8000_0000);

    // MTLO, then a flushed MULT must leave LO alone
    mdu.op = OP_MTLO; mdu.a = 32'h1234; mdu.start = 1'b1;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    check("mtlo_lo", 64'(mdu.lo), 64'h1234);
    check("mtlo_busy", 64'(mdu.busy), 64'(0));
    check("mtlo_done", 64'(mdu.done), 64'(0));
    mdu.op = OP_MTHI; mdu.a = 32'hBEEF; mdu.start = 1'b1;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    check("mthi_hi", 64'(mdu.hi), 64'hBEEF);
    run_op(OP_MULT, 32'd3, 32'd5, 10, 0, 0, dc, bc, nc);
    check("flush_no_done", 64'(nc), 64'(0));
    check("flush_lo_kept", 64'(mdu.lo), 64'h1234);
    check("flush_hi_kept", 64'(mdu.hi), 64'hBEEF);

    // start together with flush in IDLE is discarded
    mdu.op = OP_MTLO; mdu.a = 32'h5555; mdu.start = 1'b1; mdu.flush = 1'b1;
    @(posedge clk); #1;
    mdu.start = 1'b0; mdu.flush = 1'b0;
    check("idle_flush_start", 64'(mdu.lo), 64'h1234);

    // second start plus MFHI access during a DIVU
    model(OP_DIVU, 32'd1000, 32'd7, eh, el);
    run_op(OP_DIVU, 32'd1000, 32'd7, 0, 5, 0, dc, bc, nc);
    check("extra_done_count", 64'(nc), 64'(1));
    check("extra_done_cycle", 64'(dc), 64'(W + 2));
    check("extra_hi", 64'(mdu.hi), 64'(eh));
    check("extra_lo", 64'(mdu.lo), 64'(el));
    check("extra_idle_after", 64'(mdu.busy), 64'(0));

    // reset mid-DIV
    run_op(OP_DIV, 32'hFFFF_0000, 32'd12345, 0, 0, 20, dc, bc, nc);
    check("reset_no_done", 64'(nc), 64'(0));

    // random back-to-back operations
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_and_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It adds `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. The unit sits beside the EX-stage ALU and accepts one operation per start pulse. It raises a stall request toward the hazard logic while a result is pending and a dependent access arrives, and it supports flush of an in-flight operation on a taken branch.

## Interface
- `DATA_WIDTH`, 32: operand width and HI/LO width; must be even and ≥ 4.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a new operation this cycle.
- `op` in 3: operation code, encodings from `mdu_pkg`: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; values 6–7 are NOP.
- `a` in `DATA_WIDTH`: rs operand (dividend, multiplicand, or MTHI/MTLO source).
- `b` in `DATA_WIDTH`: rt operand (divisor or multiplier).
- `flush` in 1: cancel the in-flight operation.
- `mf_access` in 1: an MFHI/MFLO is in ID this cycle.
- `busy` out 1: an iterative operation is in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `stall` out 1: combinational, equals `busy & (mf_access | start)`.
- `hi` out `DATA_WIDTH`: HI register, remainder or upper product.
- `lo` out `DATA_WIDTH`: LO register, quotient or lower product.

## Operation
- States (`mdu_pkg` enum): IDLE, RUN, FIX.
- Reset: state IDLE; `hi`, `lo`, `busy`, `done` and the iteration counter all 0.
- IDLE, `start` with MTHI/MTLO: `hi` or `lo` is loaded with `a` at the clock edge. State stays IDLE; `busy` and `done` are not asserted.
- IDLE, `start` with ops 0–3: latch operand magnitudes, the signs `sa`/`sb` (signed ops only), and the op. Clear the counter and go to RUN.
- IDLE, `start` with NOP: ignored.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2·`DATA_WIDTH`-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN length: exactly `DATA_WIDTH` cycles, then FIX.
- FIX, signed multiply: negate the 2W product if `sa^sb`.
- FIX, signed divide: negate the quotient if `sa^sb`; negate the remainder if `sa`.
- FIX exit: write `hi`/`lo`, go to IDLE, pulse `done`.
- Divide by zero: no trap. Result is LO = all ones and HI = |a|, with the sign fix applied for signed ops. For example, DIVU 7/0 gives HI=7, LO=0xFFFFFFFF.
- DIV with a = most negative and b = −1: LO = most negative, HI = 0. No exception.
- `start` while `busy`: ignored. The pipeline is already held by `stall`.
- `flush` in RUN or FIX: return to IDLE next edge. `hi`/`lo` are left unchanged and `done` is not asserted.
- `flush` together with `start` in IDLE: the start is discarded.
- `reset` overrides everything, mid-operation included.

## Timing
- Cycle 0: `start` is sampled.
- `busy` is high in cycles 1 through `DATA_WIDTH`+1.
- `done` is high in cycle `DATA_WIDTH`+2, the same cycle the new `hi`/`lo` are visible and `busy` is low. Total latency is W+2 cycles (34 at W=32).
- MTHI/MTLO: value visible in cycle 1.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one operation per W+2 cycles.
- `stall` is combinational from its inputs, with no added register. The ID-stage read of `hi`/`lo` occurs when `stall` is low.

## Structure
- `mdu_pkg`: op encodings, state enum, and a `neg(x)` two's-complement function.
- `mult_div_unit` is a single module.
- The shared shift register (accumulator for multiply, partial remainder for divide) is a sub-module, `mdu_shift_core`, with `DATA_WIDTH` passed through.

## Test plan
- Reset, then no stimulus: `hi`=`lo`=0, `busy`=`done`=`stall`=0.
- MULT a=0xFFFFFFFF, b=2: `done` at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=−7, b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0: LO=0xFFFFFFFF, HI=7.
- DIV a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTLO 0x1234, then MULT 3×5 with `flush` at cycle 10: LO stays 0x1234, `done` never pulses, `busy` is low at cycle 11.
- A second `start` and `mf_access` at cycle 5 of a DIVU: `stall`=1 while `busy`; the second start is ignored; exactly one `done` pulse.
- `reset` at cycle 20 of a DIV: at the next cycle state is IDLE and `hi`=`lo`=0.
